// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants for the multi-channel clock divider
//
// Purpose: default counter width and the per-channel mode encoding used by
//          div_channel and multi_clk_divider.
// Ports:   none (package).
package div_pkg;

  localparam int   DEFAULT_CNT_W = 24;

  localparam logic MODE_TOGGLE   = 1'b0;
  localparam logic MODE_PWM      = 1'b1;

endpackage

// File: rtl/div_channel.sv
// rtl/div_channel.sv - one divider channel: counter, shadow registers, out/tick
//
// Purpose: counts enabled cycles from 0 to the shadowed terminal count, then
//          wraps. Period, duty and mode are captured only at the wrap, so a
//          reprogram never cuts a running period short.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   en_i      run enable; when low all state holds and tick_o is 0
//   mode_i    0 = toggle, 1 = PWM (captured at wrap)
//   period_i  terminal count P, period is P+1 cycles (captured at wrap)
//   duty_i    PWM high time D in cycles (captured at wrap)
//   out_o     registered divided / PWM output
//   tick_o    registered one-cycle strobe on the cycle after a wrap
module div_channel
  import div_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [CNT_W-1:0] per_q,  per_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             mode_q, mode_d;
  logic             out_q,  out_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    wrap   = en_i && (cnt_q == per_q);
    cnt_d  = cnt_q;
    per_d  = per_q;
    duty_d = duty_q;
    mode_d = mode_q;
    out_d  = out_q;
    tick_d = 1'b0;

    if (en_i) begin
      if (wrap) begin
        cnt_d  = '0;
        per_d  = period_i;
        duty_d = duty_i;
        mode_d = mode_i;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      // The output is judged against the post-edge counter and the freshly
      // loaded shadows, so a mode or duty change lands cleanly at the wrap
      // and D>P stays high straight through it.
      if (mode_d == MODE_PWM) begin
        out_d = (cnt_d < duty_d);
      end else if (wrap) begin
        out_d = ~out_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      per_q  <= '0;
      duty_q <= '0;
      mode_q <= MODE_TOGGLE;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      duty_q <= duty_d;
      mode_q <= mode_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/multi_clk_divider.sv
// rtl/multi_clk_divider.sv - NUM_CH independent synchronous clock dividers
//
// Purpose: replicates div_channel NUM_CH times; this level only slices the
//          packed period/duty buses. Tick outputs serve as clock enables.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   en        [NUM_CH]        per-channel run enable
//   mode_i    [NUM_CH]        per-channel mode (0 toggle, 1 PWM)
//   period_i  [NUM_CH*CNT_W]  channel c at [c*CNT_W +: CNT_W]
//   duty_i    [NUM_CH*CNT_W]  same slicing as period_i
//   out       [NUM_CH]        registered divided / PWM outputs
//   tick      [NUM_CH]        registered wrap strobes
module multi_clk_divider
  import div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*CNT_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] duty_i,
  output logic [NUM_CH-1:0]       out,
  output logic [NUM_CH-1:0]       tick
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    div_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en_i     (en[c]),
      .mode_i   (mode_i[c]),
      .period_i (period_i[c*CNT_W +: CNT_W]),
      .duty_i   (duty_i[c*CNT_W +: CNT_W]),
      .out_o    (out[c]),
      .tick_o   (tick[c])
    );
  end

endmodule

// File: doc/multi_clk_divider.md
Name: multi_clk_divider

Overview:
- Parametrised, fully synchronous successor to the single-output ripple divider used for LED blinking.
- Provides NUM_CH independent channels clocked from the one system clock; no derived clocks.
- Each channel has a run-time programmable period, a toggle (square-wave) or PWM mode, and a one-cycle wrap strobe.
- Sits between board clock/reset and LEDs or low-rate peripherals; the tick outputs double as clock enables for downstream logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (≥1).
- CNT_W, 24, counter width per channel; maximum period is 2^CNT_W cycles.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  NUM_CH  per-channel run enable.
- mode_i  input  NUM_CH  per-channel mode: 0 = toggle, 1 = PWM.
- period_i  input  NUM_CH*CNT_W  per-channel terminal count P; channel c uses bits [c*CNT_W +: CNT_W].
- duty_i  input  NUM_CH*CNT_W  per-channel PWM high time D in cycles; same slicing as period_i.
- out  output  NUM_CH  registered divided/PWM output.
- tick  output  NUM_CH  registered one-cycle strobe, asserted on the cycle after a wrap.

Behaviour:
- Per-channel state: cnt[CNT_W], shadow per_q, duty_q, mode_q, plus registered out and tick. Channels are fully independent.
- Reset (rst=0, asynchronous): cnt=0, per_q=0, duty_q=0, mode_q=0, out=0, tick=0 for all channels. Release is synchronous to the next clk edge.
- en[c]=0: cnt, shadows and out hold; tick=0.
- en[c]=1, cnt==per_q (wrap):
  - cnt←0; tick←1.
  - Load shadows: per_q←period_i slice, duty_q←duty_i slice, mode_q←mode_i.
- en[c]=1, otherwise: cnt←cnt+1; tick←0.
- Period is per_q+1 cycles.
- Inputs are sampled only at wrap, so a period or mode change never truncates or glitches the current period.
- After reset, the first enabled cycle always wraps (per_q=0) and loads the programmed values.
- out, computed from post-edge values (next cnt, newly loaded shadows):
  - Toggle mode: out inverts on every wrap, including the first. Output period is 2*(P+1) cycles, 50% duty.
  - PWM mode: out←(next cnt < next duty_q). High for D cycles of every P+1.
  - D=0 gives constant 0. D>P gives constant 1, with no glitch at the wrap.
- Mode switch takes effect at the wrap that loads it.
  - Toggle→PWM: out is set by the PWM compare from that edge.
  - PWM→toggle: out inverts from its current value at that edge.
- P=0: wrap every cycle. tick stays high continuously; toggle out becomes clk/2.
- P=2^CNT_W−1: cnt reaches all-ones and wraps to 0. No overflow beyond the compare is possible.
- Arithmetic: unsigned, CNT_W-bit compares; no saturation needed.
- Reset mid-period clears immediately. After release, behaviour is identical to a cold start.
- Latency: tick and out change on the edge where the wrap/compare is evaluated; no further pipeline stage.

Decomposition:
- Package div_pkg:
  - default CNT_W constant;
  - mode encoding constants MODE_TOGGLE=1'b0, MODE_PWM=1'b1.
- Sub-module div_channel (one channel: counter, shadows, out/tick logic).
  - Instantiated NUM_CH times in a generate loop.
  - Top level only slices the packed buses.

Test Plan:
- Reset: hold rst=0 with en=all-ones and P=5 → out=0, tick=0 throughout. Release → first tick on the first enabled edge.
- Toggle: ch0 mode=0, P=3, en=1 from reset → tick every 4 cycles; out period 8 cycles, 4 high / 4 low.
- PWM: ch1 mode=1, P=9, D=3 → out high exactly 3 of every 10 cycles, rising with each tick. D=0 → out stays 0. D=10 → out stays 1 with no 1-cycle dip at wrap.
- Mid-period reprogram: ch2 P=7 running; change period_i to 2 at cnt=3 → current period completes at 8 cycles, then tick every 3 cycles.
- Enable gating: drop en[0] for 5 cycles at cnt=2 → cnt, out hold and tick=0. Resume → the wrap arrives 5 cycles later than it would have.
- Edge cases and independence:
  - P=0, mode=0 → tick constantly 1 and out toggles every cycle.
  - Assert rst mid-PWM-high → out=0 asynchronously.
  - Run all 4 channels with different P/D simultaneously → check no cross-channel interaction.
